// File: rtl/cl_ocl_axil_arbiter.sv
// Two-requester AXI-Lite arbiter in front of the OCL register slave.
// One transaction in flight, round-robin between requesters, write before
// read within a requester, and a response watchdog that answers SLVERR to
// the requester and then silently drains the late slave response.
module cl_ocl_axil_arbiter #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       TIMEOUT_CYC = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(32'hDEAD_DEAD)
) (
  input  logic                  clk_main_a0,
  input  logic                  rst_main,
  // requester side
  input  logic [1:0]            s_awvalid,
  output logic [1:0]            s_awready,
  input  logic [2*ADDR_W-1:0]   s_awaddr,
  input  logic [1:0]            s_wvalid,
  output logic [1:0]            s_wready,
  input  logic [2*DATA_W-1:0]   s_wdata,
  input  logic [2*DATA_W/8-1:0] s_wstrb,
  output logic [1:0]            s_bvalid,
  output logic [3:0]            s_bresp,
  input  logic [1:0]            s_bready,
  input  logic [1:0]            s_arvalid,
  output logic [1:0]            s_arready,
  input  logic [2*ADDR_W-1:0]   s_araddr,
  output logic [1:0]            s_rvalid,
  output logic [2*DATA_W-1:0]   s_rdata,
  output logic [3:0]            s_rresp,
  input  logic [1:0]            s_rready,
  // slave side
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  // status
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [15:0]           timeout_cnt
);

  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_REQ, ST_RD_REQ, ST_WR_RESP, ST_RD_RESP, ST_ERR, ST_FLUSH
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_g, w_g_nxt;
  logic            r_last, w_last_nxt;
  logic            r_is_wr, w_is_wr_nxt;
  logic            r_aw_done, w_aw_done_nxt;
  logic            r_w_done, w_w_done_nxt;
  logic [WD_W-1:0] r_wd_cnt, w_wd_nxt;
  logic [15:0]     r_timeout_cnt, w_tcnt_nxt;

  logic [1:0]        w_wr_req, w_req;
  logic              w_first, w_pick;
  logic              w_awready, w_wready, w_arready;
  logic              w_bvalid, w_rvalid;
  logic [1:0]        w_bresp, w_rresp;
  logic [DATA_W-1:0] w_rdata;
  logic [15:0]       w_tcnt_inc;

  assign w_wr_req   = s_awvalid & s_wvalid;
  assign w_req      = w_wr_req | s_arvalid;
  assign w_first    = ~r_last;
  assign w_tcnt_inc = (r_timeout_cnt == '1) ? r_timeout_cnt : r_timeout_cnt + 16'd1;

  assign busy        = (r_state != ST_IDLE);
  assign grant       = busy ? (r_g ? 2'b10 : 2'b01) : 2'b00;
  assign timeout_cnt = r_timeout_cnt;

  // State and bookkeeping registers
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      r_state       <= ST_IDLE;
      r_g           <= 1'b0;
      r_last        <= 1'b1;
      r_is_wr       <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_wd_cnt      <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_g           <= w_g_nxt;
      r_last        <= w_last_nxt;
      r_is_wr       <= w_is_wr_nxt;
      r_aw_done     <= w_aw_done_nxt;
      r_w_done      <= w_w_done_nxt;
      r_wd_cnt      <= w_wd_nxt;
      r_timeout_cnt <= w_tcnt_nxt;
    end
  end

  // Next-state logic, slave-side handshakes and requester-side demux
  always_comb begin
    w_state_nxt   = r_state;
    w_g_nxt       = r_g;
    w_last_nxt    = r_last;
    w_is_wr_nxt   = r_is_wr;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_wd_nxt      = r_wd_cnt;
    w_tcnt_nxt    = r_timeout_cnt;
    w_pick        = 1'b0;

    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_arready = 1'b0;
    w_bvalid  = 1'b0;
    w_bresp   = 2'b00;
    w_rvalid  = 1'b0;
    w_rresp   = 2'b00;
    w_rdata   = '0;

    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_arvalid = 1'b0;
    m_bready  = 1'b0;
    m_rready  = 1'b0;
    m_awaddr  = r_g ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
    m_araddr  = r_g ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
    m_wdata   = r_g ? s_wdata[2*DATA_W-1:DATA_W]  : s_wdata[DATA_W-1:0];
    m_wstrb   = r_g ? s_wstrb[2*DATA_W/8-1:DATA_W/8] : s_wstrb[DATA_W/8-1:0];

    unique case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_pick      = w_req[w_first] ? w_first : r_last;
          w_g_nxt     = w_pick;
          w_last_nxt  = w_pick;
          w_is_wr_nxt = w_wr_req[w_pick];
          w_state_nxt = w_wr_req[w_pick] ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        m_awvalid = ~r_aw_done;
        m_wvalid  = ~r_w_done;
        w_awready = m_awready & ~r_aw_done;
        w_wready  = m_wready & ~r_w_done;
        // AW and W are tracked independently; both may finish in one cycle
        if ((r_aw_done | m_awready) && (r_w_done | m_wready)) begin
          w_state_nxt   = ST_WR_RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_wd_nxt      = '0;
        end else begin
          w_aw_done_nxt = r_aw_done | m_awready;
          w_w_done_nxt  = r_w_done | m_wready;
        end
      end
      ST_RD_REQ: begin
        m_arvalid = 1'b1;
        w_arready = m_arready;
        if (m_arready) begin
          w_state_nxt = ST_RD_RESP;
          w_wd_nxt    = '0;
        end
      end
      ST_WR_RESP: begin
        w_bvalid = m_bvalid;
        w_bresp  = m_bresp;
        m_bready = s_bready[r_g];
        if (m_bvalid && s_bready[r_g]) begin
          w_state_nxt = ST_IDLE;
        end else if (!m_bvalid && r_wd_cnt == WD_LAST) begin
          w_state_nxt = ST_ERR;
          w_tcnt_nxt  = w_tcnt_inc;
        end else begin
          w_wd_nxt = r_wd_cnt + WD_W'(1);
        end
      end
      ST_RD_RESP: begin
        w_rvalid = m_rvalid;
        w_rdata  = m_rdata;
        w_rresp  = m_rresp;
        m_rready = s_rready[r_g];
        if (m_rvalid && s_rready[r_g]) begin
          w_state_nxt = ST_IDLE;
        end else if (!m_rvalid && r_wd_cnt == WD_LAST) begin
          w_state_nxt = ST_ERR;
          w_tcnt_nxt  = w_tcnt_inc;
        end else begin
          w_wd_nxt = r_wd_cnt + WD_W'(1);
        end
      end
      ST_ERR: begin
        if (r_is_wr) begin
          w_bvalid = 1'b1;
          w_bresp  = 2'b10;
          if (s_bready[r_g]) w_state_nxt = ST_FLUSH;
        end else begin
          w_rvalid = 1'b1;
          w_rdata  = ERR_RDATA;
          w_rresp  = 2'b10;
          if (s_rready[r_g]) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (r_is_wr) begin
          m_bready = 1'b1;
          if (m_bvalid) w_state_nxt = ST_IDLE;
        end else begin
          m_rready = 1'b1;
          if (m_rvalid) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    s_awready = r_g ? {w_awready, 1'b0} : {1'b0, w_awready};
    s_wready  = r_g ? {w_wready, 1'b0}  : {1'b0, w_wready};
    s_arready = r_g ? {w_arready, 1'b0} : {1'b0, w_arready};
    s_bvalid  = r_g ? {w_bvalid, 1'b0}  : {1'b0, w_bvalid};
    s_rvalid  = r_g ? {w_rvalid, 1'b0}  : {1'b0, w_rvalid};
    s_bresp   = r_g ? {w_bresp, 2'b00}  : {2'b00, w_bresp};
    s_rresp   = r_g ? {w_rresp, 2'b00}  : {2'b00, w_rresp};
    s_rdata   = r_g ? {w_rdata, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, w_rdata};
  end

endmodule

// File: tb/tb_cl_ocl_axil_arbiter.sv
// Directed bench for cl_ocl_axil_arbiter: reset, round-robin reads, writes
// with split/joint AW-W acceptance, watchdog error + flush, write-before-read
// within a requester, and reset abandoning a transaction.
module tb_cl_ocl_axil_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [2*AW-1:0] s_awaddr, s_araddr;
  logic [2*DW-1:0] s_wdata, s_rdata;
  logic [2*DW/8-1:0] s_wstrb;
  logic [3:0]    s_bresp, s_rresp;
  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW/8-1:0] m_wstrb;
  logic [1:0]    m_bresp, m_rresp;
  logic [1:0]    grant;
  logic          busy;
  logic [15:0]   timeout_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cl_ocl_axil_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16), .ERR_RDATA(32'hDEAD_DEAD)
  ) dut (
    .clk_main_a0(clk), .rst_main(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .grant(grant), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  exp_g;
  logic [31:0] rd;
  int          n_rsp0 = 0;
  int          n_rsp1 = 0;

  initial begin
    rst = 1'b1;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_bready = 2'b11; s_rready = 2'b11;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = '0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    repeat (2) tick();

    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_mvalid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
    chk("rst_svalid", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}, 10'b0);
    chk("rst_tcnt", timeout_cnt, 16'd0);
    rst = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;

    // round-robin reads, both requesters asking every cycle
    s_arvalid = 2'b11;
    s_araddr  = {32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk("rr_grant", grant, exp_g);
      chk("rr_arvalid", m_arvalid, 1'b1);
      chk("rr_araddr", m_araddr, (exp_g == 2'b01) ? 32'h100 : 32'h200);
      chk("rr_arready", s_arready, exp_g);
      tick();
      rd = (exp_g == 2'b01) ? 32'hAAAA_0000 + k : 32'hBBBB_0000 + k;
      m_rvalid = 1'b1; m_rdata = rd; m_rresp = 2'b00;
      #1;
      chk("rr_rvalid", s_rvalid, exp_g);
      chk("rr_rdata", s_rdata, (exp_g == 2'b01) ? {32'h0, rd} : {rd, 32'h0});
      if (s_rvalid[0]) n_rsp0++;
      if (s_rvalid[1]) n_rsp1++;
      tick();
      m_rvalid = 1'b0;
    end
    chk("rr_cnt0", n_rsp0, 4);
    chk("rr_cnt1", n_rsp1, 4);
    s_arvalid = 2'b00;

    // requester 0 write, slave accepts immediately, bvalid two cycles later
    s_awaddr = {32'h0, 32'h0000_0500};
    s_wdata  = {32'h0, 32'h1234_5678};
    s_wstrb  = 8'h0F;
    s_awvalid = 2'b01; s_wvalid = 2'b01;
    #1;
    chk("wr0_nocomb", {m_awvalid, m_wvalid}, 2'b00);
    tick();
    chk("wr0_grant", grant, 2'b01);
    chk("wr0_mvalid", {m_awvalid, m_wvalid}, 2'b11);
    chk("wr0_awaddr", m_awaddr, 32'h500);
    chk("wr0_wdata", {m_wstrb, m_wdata}, {4'hF, 32'h1234_5678});
    chk("wr0_sready", {s_awready, s_wready}, 4'b0101);
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b00;
    #1;
    chk("wr0_resp_mvalid", {m_awvalid, m_wvalid}, 2'b00);
    chk("wr0_resp_bvalid0", s_bvalid, 2'b00);
    tick();
    m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    chk("wr0_bvalid", s_bvalid, 2'b01);
    chk("wr0_bresp", s_bresp, 4'b0000);
    chk("wr0_bready", m_bready, 1'b1);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("wr0_done_grant", grant, 2'b00);
    chk("wr0_done_busy", busy, 1'b0);

    // requester 1 write, W accepted five cycles after AW
    m_wready = 1'b0;
    s_awaddr = {32'h0000_0600, 32'h0};
    s_wdata  = {32'hCAFE_F00D, 32'h0};
    s_wstrb  = 8'h30;
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    tick();
    chk("wr1_grant", grant, 2'b10);
    chk("wr1_mvalid", {m_awvalid, m_wvalid}, 2'b11);
    chk("wr1_awaddr", m_awaddr, 32'h600);
    chk("wr1_sready", {s_awready, s_wready}, 4'b1000);
    tick();
    s_awvalid = 2'b00;
    #1;
    chk("wr1_aw_once", {m_awvalid, m_wvalid, s_awready}, 4'b0100);
    repeat (4) tick();
    chk("wr1_wait", {m_awvalid, m_wvalid, busy}, 3'b011);
    m_wready = 1'b1;
    #1;
    chk("wr1_wready", s_wready, 2'b10);
    chk("wr1_wdata", {m_wstrb, m_wdata}, {4'h3, 32'hCAFE_F00D});
    tick();
    s_wvalid = 2'b00;
    #1;
    chk("wr1_resp_mvalid", {m_awvalid, m_wvalid, s_bvalid}, 4'b0000);
    m_bvalid = 1'b1; m_bresp = 2'b01;
    #1;
    chk("wr1_bvalid", s_bvalid, 2'b10);
    chk("wr1_bresp", s_bresp, 4'b0100);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("wr1_one_b", {s_bvalid, busy}, 3'b000);

    // requester 1 write, AW and W accepted in the same cycle
    s_awaddr = {32'h0000_0604, 32'h0};
    s_wdata  = {32'h0BAD_F00D, 32'h0};
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    tick();
    chk("wr1b_mvalid", {m_awvalid, m_wvalid}, 2'b11);
    chk("wr1b_sready", {s_awready, s_wready}, 4'b1010);
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b00;
    #1;
    chk("wr1b_resp", {m_awvalid, m_wvalid, busy, grant}, 5'b00110);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    chk("wr1b_bvalid", s_bvalid, 2'b10);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("wr1b_one_b", {s_bvalid, busy}, 3'b000);

    // read timeout: slave never answers within 16 response cycles
    s_araddr = {32'h0, 32'h0000_0700};
    s_arvalid = 2'b01;
    tick();
    chk("to_grant", {grant, m_arvalid}, 3'b011);
    tick();
    s_arvalid = 2'b00;
    #1;
    chk("to_resp", {s_rvalid, m_rready}, 3'b001);
    repeat (15) tick();
    chk("to_last_cycle", {busy, s_rvalid}, 3'b100);
    s_rready = 2'b00;
    tick();
    chk("to_err_rvalid", s_rvalid, 2'b01);
    chk("to_err_rdata", s_rdata, {32'h0, 32'hDEAD_DEAD});
    chk("to_err_rresp", s_rresp, 4'b0010);
    chk("to_err_mrready", m_rready, 1'b0);
    chk("to_tcnt", timeout_cnt, 16'd1);
    tick();
    chk("to_err_hold", s_rvalid, 2'b01);
    s_rready = 2'b11;
    tick();
    chk("to_flush", {s_rvalid, m_rready, busy}, 4'b0011);
    tick();
    chk("to_flush_wait", busy, 1'b1);
    m_rvalid = 1'b1; m_rdata = 32'h1111_1111; m_rresp = 2'b00;
    #1;
    chk("to_flush_nofwd", {s_rvalid, s_rdata}, 66'h0);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("to_idle", {busy, timeout_cnt}, 17'h00001);

    // requester 0 write and read together: write first, read next
    s_awaddr = {32'h0, 32'h0000_0504};
    s_wdata  = {32'h0, 32'hA5A5_A5A5};
    s_wstrb  = 8'h0F;
    s_araddr = {32'h0, 32'h0000_0704};
    s_awvalid = 2'b01; s_wvalid = 2'b01; s_arvalid = 2'b01;
    tick();
    chk("wrd_first", {grant, m_awvalid, m_arvalid}, 4'b0110);
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b00;
    m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    chk("wrd_b", {m_arvalid, s_bvalid}, 3'b001);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("wrd_idle", busy, 1'b0);
    tick();
    chk("wrd_read", {grant, m_arvalid}, 3'b011);
    chk("wrd_araddr", m_araddr, 32'h704);
    tick();
    s_arvalid = 2'b00;
    m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
    #1;
    chk("wrd_rdata", {s_rvalid, s_rdata}, {2'b01, 32'h0, 32'h5555_AAAA});
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("wrd_done", busy, 1'b0);

    // reset while requester 1 waits in the write response phase
    s_awaddr = {32'h0000_0608, 32'h0};
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    tick();
    chk("rstm_grant", grant, 2'b10);
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b00;
    #1;
    chk("rstm_inresp", {busy, m_bready}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstm_state", {busy, grant}, 3'b000);
    chk("rstm_valids", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 7'b0);
    chk("rstm_tcnt", timeout_cnt, 16'd0);
    s_araddr = {32'h0000_0200, 32'h0000_0100};
    s_arvalid = 2'b11;
    tick();
    chk("rstm_first", grant, 2'b01);
    chk("rstm_araddr", m_araddr, 32'h100);
    tick();
    s_arvalid = 2'b00;
    m_rvalid = 1'b1; m_rdata = 32'h0;
    #1;
    chk("rstm_rvalid", s_rvalid, 2'b01);
    tick();
    m_rvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cl_ocl_axil_arbiter.md
Name: cl_ocl_axil_arbiter

Overview:
- Two-requester AXI-Lite arbiter for the OCL register slave (the hello-world/VLED register file behind the BAR0 register slice).
- Lets a second internal master (e.g. VIO/debug sequencer) share the slave with the PCIe OCL path.
- One transaction in flight at a time. Round-robin between requesters; write wins over read within a requester.
- Response watchdog returns SLVERR to the requester if the slave stalls, then drains the late response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (strobe width DATA_W/8)
TIMEOUT_CYC, 256, max cycles in a response state before error completion (min 2)
ERR_RDATA, 32'hDEAD_DEAD, rdata returned on read timeout

Ports:
clk_main_a0 in 1 clock
rst_main in 1 synchronous active-high reset
s_awvalid/s_awready in/out 2 per-requester write address handshake (bit i = requester i)
s_awaddr in 2*ADDR_W requester i at [i*ADDR_W +: ADDR_W]
s_wvalid/s_wready in/out 2 write data handshake
s_wdata in 2*DATA_W; s_wstrb in 2*DATA_W/8
s_bvalid out 2; s_bresp out 2*2; s_bready in 2
s_arvalid/s_arready in/out 2; s_araddr in 2*ADDR_W
s_rvalid out 2; s_rdata out 2*DATA_W; s_rresp out 2*2; s_rready in 2
m_awvalid/m_awready out/in 1; m_awaddr out ADDR_W
m_wvalid/m_wready out/in 1; m_wdata out DATA_W; m_wstrb out DATA_W/8
m_bvalid/m_bready in/out 1; m_bresp in 2
m_arvalid/m_arready out/in 1; m_araddr out ADDR_W
m_rvalid/m_rready in/out 1; m_rdata in DATA_W; m_rresp in 2
grant out 2 one-hot granted requester, 0 when IDLE
busy out 1 state != IDLE
timeout_cnt out 16 saturating count of timeouts

Behaviour:
- Reset (rst_main sampled high at a clock edge):
  - state=IDLE, last_grant=1 (requester 0 wins first), aw_done=w_done=0, wd_cnt=0, timeout_cnt=0.
  - All valid/ready outputs 0.
  - Reset mid-transaction abandons it; no response is issued.
- Request of requester i: wr_req[i]=s_awvalid[i]&s_wvalid[i]; rd_req[i]=s_arvalid[i].
- IDLE pick:
  - Candidate order starts at requester (last_grant+1)%2, then last_grant. First requester with wr_req|rd_req wins.
  - The winner's write goes if wr_req, else its read.
  - Register g and last_grant=g; go to WR_REQ or RD_REQ. Arbitration takes 1 cycle; m_*valid rises the cycle after the request is seen.
- WR_REQ:
  - m_awvalid=!aw_done; m_wvalid=!w_done. m_aw*/m_w* muxed from requester g.
  - s_awready[g]=m_awready&!aw_done; s_wready[g]=m_wready&!w_done.
  - AW and W complete independently; set aw_done/w_done on handshake. Both done (including same cycle) -> WR_RESP, clear flags and wd_cnt.
- RD_REQ: m_arvalid=1, s_arready[g]=m_arready; handshake -> RD_RESP, wd_cnt=0.
- WR_RESP / RD_RESP:
  - Pass-through: s_bvalid[g]=m_bvalid, m_bready=s_bready[g], bresp forwarded; likewise for r*.
  - Handshake -> IDLE.
  - Else wd_cnt++. When wd_cnt==TIMEOUT_CYC-1 with no slave valid -> ERR; timeout_cnt++ (saturates at 16'hFFFF).
- ERR:
  - s_bvalid[g]=1 with bresp=2'b10, or s_rvalid[g]=1 with rdata=ERR_RDATA, rresp=2'b10. m_bready/m_rready=0.
  - Requester handshake -> FLUSH.
- FLUSH: m_bready (or m_rready)=1, nothing forwarded to requesters. Slave valid seen -> IDLE. No timeout; waits indefinitely.
- Non-granted requester: all its ready/valid outputs are 0. Its data outputs are don't-care but driven 0.
- grant/busy are combinational from registered state; no combinational path from s_*valid to m_*valid.
- Both requesters rd+wr in the same IDLE cycle: round-robin picks the requester, write goes first, the read waits for a later grant.

Test Plan:
- Req0 write addr 0x500 data 0x1234_5678 (slave awready/wready=1, bvalid 2 cycles later) -> m_awvalid/m_wvalid rise 1 cycle after request; s_bvalid[0] with bresp=0; grant=2'b01 during, 0 after.
- Both requesters issue reads every cycle for 8 transactions -> grants alternate 0,1,0,1…, first to requester 0; each requester gets 4 responses with its own rdata.
- Req1 write with m_wready delayed 5 cycles after m_awready, then same-cycle AW/W acceptance on a second write -> single m_awvalid/m_wvalid handshake each; exactly one s_bvalid[1] per write.
- Slave never asserts rvalid with TIMEOUT_CYC=16 -> after 16 cycles in RD_RESP, s_rvalid[0]=1, rdata=0xDEAD_DEAD, rresp=2'b10, timeout_cnt=1. State FLUSH until slave rvalid arrives, which is consumed with m_rready=1 and not forwarded; then IDLE.
- Req0 asserts awvalid+wvalid+arvalid simultaneously -> write serviced first, read on the next grant to requester 0.
- Assert rst_main for 1 cycle while in WR_RESP -> next cycle busy=0, grant=0, all m_*valid/s_*valid=0, timeout_cnt=0; next request goes to requester 0.
